// File: rtl/seg_display_scheduler.sv
// Page scheduler for a 16-bit, two-byte display. It rotates through the written channels and
// can interrupt the rotation with a timed alert.
// Latency: a shadow write at edge N shows on MSB/LSB after edge N+1. Page and alert changes show
// after the edge that makes them.
// Backpressure: alert_ready is low while an alert is shown, and an offered alert is then dropped.
// Ports:
//   clk50, reset (async, active-low)                   - clock and reset
//   upd_valid[3:0], upd_data[63:0]                     - per-channel shadow writes
//   manual_next, pin_en                                - page advance pulse, rotation freeze
//   alert_valid/alert_ready, alert_data                - alert handshake
//   MSB, LSB, page, alert_active, seen_mask            - registered display outputs
module seg_display_scheduler #(
  parameter int unsigned HOLD_CYCLES  = 50_000_000,
  parameter int unsigned ALERT_CYCLES = 100_000_000
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic [3:0]  upd_valid,
  input  logic [63:0] upd_data,
  input  logic        manual_next,
  input  logic        pin_en,
  input  logic        alert_valid,
  input  logic [15:0] alert_data,
  output logic        alert_ready,
  output logic [7:0]  MSB,
  output logic [7:0]  LSB,
  output logic [1:0]  page,
  output logic        alert_active,
  output logic [3:0]  seen_mask
);

  localparam int unsigned CMAX = (HOLD_CYCLES > ALERT_CYCLES) ? HOLD_CYCLES : ALERT_CYCLES;
  localparam int CW = $clog2(CMAX);

  typedef enum logic [1:0] {ST_EMPTY, ST_ROTATE, ST_ALERT} state_e;

  state_e           state_q, state_d;
  logic [3:0][15:0] shadow_q, shadow_d;
  logic [3:0]       seen_q, seen_d;
  logic [1:0]       page_q, page_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      alert_q, alert_d;
  logic [15:0]      disp_q, disp_d;
  logic             active_q;

  logic             accept;
  logic             hold_tc;
  logic             alert_tc;
  logic [1:0]       adv_page;
  logic [1:0]       low_page;
  logic [1:0]       cand;
  logic             found;

  assign accept   = alert_valid && (state_q != ST_ALERT);
  assign hold_tc  = (cnt_q == CW'(HOLD_CYCLES - 1));
  assign alert_tc = (cnt_q == CW'(ALERT_CYCLES - 1));

  // Shadow registers and the seen flags. These keep updating in every state, alerts included.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < 4; i++) begin
      if (upd_valid[i]) shadow_d[i] = upd_data[16*i +: 16];
    end
    seen_d = seen_q | upd_valid;
  end

  // Search forward from page_q for the next seen channel, wrapping modulo 4. If no other
  // channel has been seen, the current page is kept.
  always_comb begin
    adv_page = page_q;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k < 4; k++) begin
      cand = page_q + 2'(k);
      if (!found && seen_q[cand]) begin
        adv_page = cand;
        found    = 1'b1;
      end
    end
  end

  assign low_page = upd_valid[0] ? 2'd0 :
                    upd_valid[1] ? 2'd1 :
                    upd_valid[2] ? 2'd2 : 2'd3;

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    cnt_d   = cnt_q;
    alert_d = alert_q;
    unique case (state_q)
      ST_EMPTY: begin
        // An alert outranks the first channel write. The page stays 0 in that case.
        if (accept) begin
          state_d = ST_ALERT;
          alert_d = alert_data;
          cnt_d   = '0;
        end else if (|upd_valid) begin
          state_d = ST_ROTATE;
          page_d  = low_page;
          cnt_d   = '0;
        end
      end
      ST_ROTATE: begin
        if (accept) begin
          state_d = ST_ALERT;
          alert_d = alert_data;
          cnt_d   = '0;
        end else if (manual_next || (hold_tc && !pin_en)) begin
          // A manual pulse that lands on terminal count still gives a single advance.
          page_d = adv_page;
          cnt_d  = '0;
        end else if (!hold_tc) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ALERT: begin
        if (manual_next || alert_tc) begin
          // Use the post-write seen mask. Otherwise a write on the exit edge could leave the
          // scheduler in EMPTY with channels already seen.
          state_d = (seen_d == 4'd0) ? ST_EMPTY : ST_ROTATE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // The display uses the next state and page with the pre-edge shadows. This gives the
  // one-cycle lag on shadow changes, while a page change shows immediately.
  always_comb begin
    disp_d = 16'h0000;
    if (state_d == ST_ALERT)       disp_d = alert_d;
    else if (state_d == ST_ROTATE) disp_d = shadow_q[page_d];
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_EMPTY;
      shadow_q <= '0;
      seen_q   <= '0;
      page_q   <= '0;
      cnt_q    <= '0;
      alert_q  <= '0;
      disp_q   <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      seen_q   <= seen_d;
      page_q   <= page_d;
      cnt_q    <= cnt_d;
      alert_q  <= alert_d;
      disp_q   <= disp_d;
      active_q <= (state_d == ST_ALERT);
    end
  end

  assign alert_ready  = (state_q != ST_ALERT);
  assign MSB          = disp_q[15:8];
  assign LSB          = disp_q[7:0];
  assign page         = page_q;
  assign alert_active = active_q;
  assign seen_mask    = seen_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
module tb_seg_display_scheduler;

  localparam int H = 8;
  localparam int A = 4;

  logic        clk50;
  logic        reset;
  logic [3:0]  upd_valid;
  logic [63:0] upd_data;
  logic        manual_next;
  logic        pin_en;
  logic        alert_valid;
  logic [15:0] alert_data;
  logic        alert_ready;
  logic [7:0]  MSB;
  logic [7:0]  LSB;
  logic [1:0]  page;
  logic        alert_active;
  logic [3:0]  seen_mask;

  seg_display_scheduler #(.HOLD_CYCLES(H), .ALERT_CYCLES(A)) dut (
    .clk50(clk50), .reset(reset), .upd_valid(upd_valid), .upd_data(upd_data),
    .manual_next(manual_next), .pin_en(pin_en), .alert_valid(alert_valid),
    .alert_data(alert_data), .alert_ready(alert_ready), .MSB(MSB), .LSB(LSB),
    .page(page), .alert_active(alert_active), .seen_mask(seen_mask)
  );

  initial begin
    clk50 = 1'b0;
    forever #5 clk50 = ~clk50;
  end

  typedef struct {
    logic [1:0]  page;
    logic [15:0] disp;
    logic        act;
    logic        rdy;
    logic [3:0]  seen;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model. The hold and alert timers count down the cycles left; page search is
  // modular arithmetic over the seen flags.
  bit          m_alert;
  bit          m_rot;
  int          m_page;
  int          m_left;
  int          m_aleft;
  logic [15:0] m_aval;
  logic [15:0] m_sh[4];
  bit          m_seen[4];

  task automatic model_reset();
    m_alert = 0; m_rot = 0; m_page = 0; m_left = H - 1; m_aleft = A - 1; m_aval = '0;
    for (int i = 0; i < 4; i++) begin
      m_sh[i] = '0;
      m_seen[i] = 0;
    end
  endtask

  function automatic int next_seen(int from);
    for (int d = 1; d < 4; d++) begin
      if (m_seen[(from + d) % 4]) return (from + d) % 4;
    end
    return from;
  endfunction

  task automatic model_step(input logic [3:0] uv, input logic [63:0] ud, input bit mn,
                            input bit pin, input bit av, input logic [15:0] ad);
    bit          new_seen[4];
    bit          any_seen;
    logic [15:0] old_sh[4];
    exp_t        e;
    any_seen = 0;
    for (int i = 0; i < 4; i++) begin
      old_sh[i]   = m_sh[i];
      new_seen[i] = m_seen[i] | uv[i];
      any_seen    = any_seen | new_seen[i];
    end
    if (m_alert) begin
      if (mn || m_aleft == 0) begin
        m_alert = 0;
        m_rot   = any_seen;
        m_left  = H - 1;
      end else begin
        m_aleft--;
      end
    end else if (av) begin
      m_alert = 1;
      m_aval  = ad;
      m_aleft = A - 1;
    end else if (m_rot) begin
      if (mn || (m_left == 0 && !pin)) begin
        m_page = next_seen(m_page);
        m_left = H - 1;
      end else if (m_left > 0) begin
        m_left--;
      end
    end else if (uv != 0) begin
      m_rot = 1;
      m_left = H - 1;
      for (int i = 3; i >= 0; i--) if (uv[i]) m_page = i;
    end
    for (int i = 0; i < 4; i++) begin
      m_seen[i] = new_seen[i];
      if (uv[i]) m_sh[i] = ud[16*i +: 16];
    end
    e.page = 2'(m_page);
    e.disp = m_alert ? m_aval : (m_rot ? old_sh[m_page] : 16'h0000);
    e.act  = m_alert;
    e.rdy  = !m_alert;
    for (int i = 0; i < 4; i++) e.seen[i] = m_seen[i];
    exp_q.push_back(e);
  endtask

  // Monitor: every clock edge presents a new output word, which is checked against the oldest
  // expectation.
  always @(posedge clk50) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("page", 32'(page), 32'(e.page));
      chk("display", 32'({MSB, LSB}), 32'(e.disp));
      chk("alert_active", 32'(alert_active), 32'(e.act));
      chk("alert_ready", 32'(alert_ready), 32'(e.rdy));
      chk("seen_mask", 32'(seen_mask), 32'(e.seen));
    end
  end

  // Drive one clock cycle of inputs and queue the response the model expects after that edge.
  task automatic cyc(input logic [3:0] uv, input logic [63:0] ud, input bit mn, input bit pin,
                     input bit av, input logic [15:0] ad);
    @(negedge clk50);
    upd_valid = uv; upd_data = ud; manual_next = mn; pin_en = pin;
    alert_valid = av; alert_data = ad;
    model_step(uv, ud, mn, pin, av && alert_ready, ad);
    @(posedge clk50);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'h0, 64'h0, 0, 0, 0, 16'h0);
  endtask

  task automatic do_reset();
    @(negedge clk50);
    reset = 1'b0;
    upd_valid = '0; upd_data = '0; manual_next = 0; pin_en = 0; alert_valid = 0; alert_data = '0;
    model_reset();
    repeat (2) @(negedge clk50);
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] uv;
    logic [63:0] ud;
    bit pin;
    reset = 1'b0;
    upd_valid = '0; upd_data = '0; manual_next = 0; pin_en = 0; alert_valid = 0; alert_data = '0;
    model_reset();
    #2;
    chk("reset_display", 32'({MSB, LSB}), 32'h0);
    chk("reset_page", 32'(page), 32'h0);
    chk("reset_alert_active", 32'(alert_active), 32'h0);
    chk("reset_alert_ready", 32'(alert_ready), 32'h1);
    chk("reset_seen", 32'(seen_mask), 32'h0);
    repeat (2) @(negedge clk50);
    reset = 1'b1;

    // Channels 0 and 2 written together, then a full rotation.
    cyc(4'b0101, {16'h0, 16'hABCD, 16'h0, 16'h1234}, 0, 0, 0, 16'h0);
    idle(1);
    chk("ex1_page0", 32'(page), 32'h0);
    chk("ex1_msb", 32'(MSB), 32'h12);
    chk("ex1_lsb", 32'(LSB), 32'h34);
    idle(7);
    chk("ex1_page2", 32'(page), 32'h2);
    chk("ex1_msb2", 32'(MSB), 32'hAB);
    idle(8);
    chk("ex1_back0", 32'(page), 32'h0);

    // Only channel 3 seen: a manual advance stays on page 3. Pinned rotation holds the page.
    do_reset();
    cyc(4'b1000, {16'h7777, 48'h0}, 0, 0, 0, 16'h0);
    idle(3);
    cyc(4'h0, 64'h0, 1, 0, 0, 16'h0);
    chk("ex2_manual_self", 32'(page), 32'h3);
    cyc(4'b0010, {32'h0, 16'h1111, 16'h0}, 0, 1, 0, 16'h0);
    for (int i = 0; i < 20; i++) cyc(4'h0, 64'h0, 0, 1, 0, 16'h0);
    chk("ex2_pinned", 32'(page), 32'h3);
    idle(2);
    chk("ex2_release", 32'(page), 32'h1);

    // Alert from ROTATE that runs its full time.
    cyc(4'h0, 64'h0, 0, 0, 1, 16'hDEAD);
    chk("ex3_active", 32'(alert_active), 32'h1);
    chk("ex3_ready", 32'(alert_ready), 32'h0);
    chk("ex3_msb", 32'(MSB), 32'hDE);
    idle(3);
    chk("ex3_still", 32'(alert_active), 32'h1);
    idle(1);
    chk("ex3_done", 32'(alert_active), 32'h0);
    chk("ex3_page", 32'(page), 32'h1);

    // A write plus manual_next during the alert ends it at the retained page.
    do_reset();
    cyc(4'b0001, 64'h0000_0000_0000_4242, 0, 0, 0, 16'h0);
    cyc(4'h0, 64'h0, 0, 0, 1, 16'hBEEF);
    cyc(4'b0010, {32'h0, 16'h5555, 16'h0}, 1, 0, 1, 16'hCAFE);
    chk("ex4_ended", 32'(alert_active), 32'h0);
    chk("ex4_page", 32'(page), 32'h0);
    chk("ex4_seen1", 32'(seen_mask[1]), 32'h1);

    // A manual pulse on the terminal-count cycle advances only one page.
    do_reset();
    cyc(4'b0111, 64'h0000_3333_2222_1111, 0, 0, 0, 16'h0);
    idle(7);
    cyc(4'h0, 64'h0, 1, 0, 0, 16'h0);
    chk("ex5_single_adv", 32'(page), 32'h1);

    // Reset asserted mid-alert acts without any clock edge.
    cyc(4'h0, 64'h0, 0, 0, 1, 16'h9876);
    idle(1);
    @(negedge clk50);
    reset = 1'b0;
    #1;
    chk("ex6_display", 32'({MSB, LSB}), 32'h0);
    chk("ex6_page", 32'(page), 32'h0);
    chk("ex6_active", 32'(alert_active), 32'h0);
    chk("ex6_ready", 32'(alert_ready), 32'h1);
    chk("ex6_seen", 32'(seen_mask), 32'h0);
    do_reset();

    // Random traffic.
    pin = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 1000 == 999) do_reset();
      if ($urandom_range(0, 15) == 0) pin = ~pin;
      uv = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      ud = {$urandom, $urandom};
      cyc(uv, ud, $urandom_range(0, 19) == 0, pin, $urandom_range(0, 24) == 0,
          16'($urandom));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
